// File: rtl/vg_vec_stepper_pkg.sv
// Shared vector-generator definitions: datapath widths, beam center, stepper
// state encoding and the sign-magnitude field layout.
package vg_vec_stepper_pkg;

   localparam int VG_MAG_W  = 12;
   localparam int VG_POS_W  = 10;
   localparam int VG_CENTER = 512;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } vg_state_e;

   // Sign-magnitude delta: the sign sits directly above the magnitude field.
   function automatic int sm_sign_idx(input int mag_w);
      return mag_w;
   endfunction

endpackage

// File: rtl/vg_dda_axis.sv
// One beam axis: binary-rate accumulator whose carry steps a saturating
// position counter up or down according to the latched sign.
module vg_dda_axis
   import vg_vec_stepper_pkg::*;
#(
   parameter int POS_W  = VG_POS_W,
   parameter int MAG_W  = VG_MAG_W,
   parameter int CENTER = VG_CENTER
) (
   input  logic             clk_12MHz,
   input  logic             reset,
   input  logic             center,
   input  logic             load,
   input  logic [MAG_W:0]   dv_in,
   input  logic             step_en,
   output logic [POS_W-1:0] pos
);

   localparam int SIGN_IDX = sm_sign_idx(MAG_W);
   localparam logic [POS_W-1:0] CENTER_POS = POS_W'(CENTER);
   localparam logic [POS_W-1:0] POS_MAX    = {POS_W{1'b1}};

   logic [MAG_W-1:0] mag_q, mag_d;
   logic             sign_q, sign_d;
   logic [MAG_W-1:0] acc_q, acc_d;
   logic [POS_W-1:0] pos_q, pos_d;
   logic [MAG_W:0]   sum;

   always_comb begin
      mag_d  = mag_q;
      sign_d = sign_q;
      acc_d  = acc_q;
      pos_d  = pos_q;
      sum    = {1'b0, acc_q} + {1'b0, mag_q};

      if (step_en) begin
         acc_d = sum[MAG_W-1:0];
         // Carry out is the step; steps past either rail are dropped.
         if (sum[MAG_W]) begin
            if (sign_q) begin
               if (pos_q != '0) pos_d = pos_q - 1'b1;
            end else begin
               if (pos_q != POS_MAX) pos_d = pos_q + 1'b1;
            end
         end
      end

      if (center) begin
         pos_d = CENTER_POS;
         acc_d = '0;
      end

      if (load) begin
         mag_d  = dv_in[MAG_W-1:0];
         // Negative zero collapses to plus zero.
         sign_d = dv_in[SIGN_IDX] & (|dv_in[MAG_W-1:0]);
         acc_d  = '0;
      end
   end

   always_ff @(posedge clk_12MHz) begin
      if (reset) begin
         mag_q  <= '0;
         sign_q <= 1'b0;
         acc_q  <= '0;
         pos_q  <= CENTER_POS;
      end else begin
         mag_q  <= mag_d;
         sign_q <= sign_d;
         acc_q  <= acc_d;
         pos_q  <= pos_d;
      end
   end

   assign pos = pos_q;

endmodule

// File: rtl/vg_vec_stepper.sv
// Vector stepper: accepts a vector, holds GO to the vector timer while both
// DDA axes step the beam, then pulses vec_done once the timer ends the vector.
module vg_vec_stepper
   import vg_vec_stepper_pkg::*;
#(
   parameter int POS_W  = VG_POS_W,
   parameter int MAG_W  = VG_MAG_W,
   parameter int CENTER = VG_CENTER
) (
   input  logic             clk_12MHz,
   input  logic             reset,
   input  logic             center,
   input  logic             vec_start,
   input  logic [MAG_W:0]   dvx,
   input  logic [MAG_W:0]   dvy,
   input  logic [3:0]       intensity,
   input  logic             STOP_not,
   output logic             GO,
   output logic [POS_W-1:0] x_pos,
   output logic [POS_W-1:0] y_pos,
   output logic             beam_on,
   output logic [3:0]       z_out,
   output logic             busy,
   output logic             vec_done
);

   vg_state_e  state_q, state_d;
   logic [3:0] int_q, int_d;
   logic       idle;
   logic       center_en;
   logic       load_en;
   logic       step_en;

   assign idle      = (state_q == ST_IDLE);
   assign center_en = idle & center;
   assign load_en   = idle & vec_start;
   assign step_en   = (state_q == ST_RUN);

   always_comb begin
      state_d = state_q;
      int_d   = int_q;
      case (state_q)
         ST_IDLE: begin
            if (vec_start) begin
               int_d   = intensity;
               state_d = ST_RUN;
            end
         end
         // The terminal cycle still steps; the axes see step_en this cycle.
         ST_RUN:  if (!STOP_not) state_d = ST_DONE;
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk_12MHz) begin
      if (reset) begin
         state_q <= ST_IDLE;
         int_q   <= '0;
      end else begin
         state_q <= state_d;
         int_q   <= int_d;
      end
   end

   assign GO       = (state_q == ST_RUN);
   assign busy     = (state_q != ST_IDLE);
   assign vec_done = (state_q == ST_DONE);
   assign beam_on  = GO & (int_q != 4'd0);
   assign z_out    = GO ? int_q : 4'd0;

   vg_dda_axis #(.POS_W(POS_W), .MAG_W(MAG_W), .CENTER(CENTER)) u_axis_x (
      .clk_12MHz (clk_12MHz),
      .reset     (reset),
      .center    (center_en),
      .load      (load_en),
      .dv_in     (dvx),
      .step_en   (step_en),
      .pos       (x_pos)
   );

   vg_dda_axis #(.POS_W(POS_W), .MAG_W(MAG_W), .CENTER(CENTER)) u_axis_y (
      .clk_12MHz (clk_12MHz),
      .reset     (reset),
      .center    (center_en),
      .load      (load_en),
      .dv_in     (dvy),
      .step_en   (step_en),
      .pos       (y_pos)
   );

endmodule

// File: tb/tb_vg_vec_stepper.sv
// Bench for vg_vec_stepper: expected end positions are queued when a vector is
// issued and compared when the stepper signals vec_done.
module tb_vg_vec_stepper;

   logic        clk_12MHz;
   logic        reset;
   logic        center;
   logic        vec_start;
   logic [12:0] dvx;
   logic [12:0] dvy;
   logic [3:0]  intensity;
   logic        STOP_not;
   logic        GO;
   logic [9:0]  x_pos;
   logic [9:0]  y_pos;
   logic        beam_on;
   logic [3:0]  z_out;
   logic        busy;
   logic        vec_done;

   int n_checks = 0;
   int n_pass   = 0;
   int done_pulses = 0;
   int x_model = 512;
   int y_model = 512;
   logic [19:0] exp_q[$];

   vg_vec_stepper dut (
      .clk_12MHz (clk_12MHz),
      .reset     (reset),
      .center    (center),
      .vec_start (vec_start),
      .dvx       (dvx),
      .dvy       (dvy),
      .intensity (intensity),
      .STOP_not  (STOP_not),
      .GO        (GO),
      .x_pos     (x_pos),
      .y_pos     (y_pos),
      .beam_on   (beam_on),
      .z_out     (z_out),
      .busy      (busy),
      .vec_done  (vec_done)
   );

   initial clk_12MHz = 1'b0;
   always #5 clk_12MHz = ~clk_12MHz;

   always @(negedge clk_12MHz) if (vec_done === 1'b1) done_pulses++;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      else n_pass++;
   endtask

   // Reference: n accumulator cycles from zero give floor(n*|dv|/4096) steps,
   // all in one direction, so saturation reduces to a clamp.
   function automatic int model_pos(input int p, input logic [12:0] dv, input int n);
      int mag;
      int k;
      mag = int'(dv[11:0]);
      k   = (n * mag) / 4096;
      if (dv[12] && mag != 0) return (p - k < 0) ? 0 : p - k;
      return (p + k > 1023) ? 1023 : p + k;
   endfunction

   task automatic center_pulse();
      center = 1'b1;
      @(negedge clk_12MHz);
      center = 1'b0;
      x_model = 512;
      y_model = 512;
      chk("center_x", 32'(x_pos), 32'd512);
      chk("center_y", 32'(y_pos), 32'd512);
   endtask

   task automatic run_vector(input logic [12:0] vx, input logic [12:0] vy,
                             input logic [3:0] inten, input int n, input bit poke);
      int go_cycles;
      int pulses0;
      int ex;
      int ey;
      logic [19:0] got;
      go_cycles = 0;
      pulses0   = done_pulses;
      ex = model_pos(x_model, vx, n);
      ey = model_pos(y_model, vy, n);
      x_model = ex;
      y_model = ey;
      exp_q.push_back({ex[9:0], ey[9:0]});

      dvx = vx; dvy = vy; intensity = inten; vec_start = 1'b1;
      @(negedge clk_12MHz);
      vec_start = 1'b0;
      for (int i = 1; i <= n; i++) begin
         if (GO === 1'b1) go_cycles++;
         if (i == 1 || i == n) begin
            chk("run_z_out", 32'(z_out), 32'(inten));
            chk("run_beam_on", 32'(beam_on), 32'(inten != 4'd0));
            chk("run_busy", 32'(busy), 32'd1);
         end
         if (poke && i == 10) begin
            dvx = 13'h1FFF; dvy = 13'h1FFF; vec_start = 1'b1; center = 1'b1;
         end else begin
            vec_start = 1'b0; center = 1'b0;
         end
         STOP_not = (i == n) ? 1'b0 : 1'b1;
         @(negedge clk_12MHz);
      end
      STOP_not = 1'b1; vec_start = 1'b0; center = 1'b0;

      chk("go_cycles", 32'(go_cycles), 32'(n));
      chk("done_go", 32'(GO), 32'd0);
      chk("done_pulse", 32'(vec_done), 32'd1);
      chk("done_busy", 32'(busy), 32'd1);
      chk("done_z_out", 32'(z_out), 32'd0);
      chk("done_beam_on", 32'(beam_on), 32'd0);
      got = exp_q.pop_front();
      chk("end_x", 32'(x_pos), 32'(got[19:10]));
      chk("end_y", 32'(y_pos), 32'(got[9:0]));
      $display("vector dvx=%h dvy=%h z=%0d n=%0d -> x=%0d y=%0d (model %0d,%0d)",
               vx, vy, inten, n, x_pos, y_pos, got[19:10], got[9:0]);
      @(negedge clk_12MHz);
      chk("after_done", 32'(vec_done), 32'd0);
      chk("after_busy", 32'(busy), 32'd0);
      chk("one_pulse", 32'(done_pulses - pulses0), 32'd1);
   endtask

   initial begin
      int pulses0;
      reset = 1'b1; center = 1'b0; vec_start = 1'b0;
      dvx = '0; dvy = '0; intensity = '0; STOP_not = 1'b1;
      repeat (3) @(negedge clk_12MHz);
      reset = 1'b0;
      chk("rst_x", 32'(x_pos), 32'd512);
      chk("rst_y", 32'(y_pos), 32'd512);
      chk("rst_go", 32'(GO), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(vec_done), 32'd0);
      chk("rst_z_out", 32'(z_out), 32'd0);
      chk("rst_beam_on", 32'(beam_on), 32'd0);

      // A low STOP_not while idle must not start anything.
      STOP_not = 1'b0;
      repeat (3) @(negedge clk_12MHz);
      STOP_not = 1'b1;
      chk("idle_stop_go", 32'(GO), 32'd0);
      chk("idle_stop_busy", 32'(busy), 32'd0);

      center_pulse();
      chk("center_go", 32'(GO), 32'd0);
      chk("center_busy", 32'(busy), 32'd0);
      chk("no_done_yet", 32'(done_pulses), 32'd0);

      run_vector(13'h0064, 13'h1064, 4'd5, 4096, 1'b0);
      center_pulse();
      run_vector(13'h0064, 13'h1064, 4'd5, 1024, 1'b0);

      center_pulse();
      run_vector(13'h0FFF, 13'h0000, 4'd3, 489, 1'b0);
      run_vector(13'h0FFF, 13'h0000, 4'd3, 4096, 1'b0);

      center_pulse();
      run_vector(13'h1FFF, 13'h0000, 4'd3, 503, 1'b0);
      run_vector(13'h1FFF, 13'h1000, 4'd3, 100, 1'b0);

      run_vector(13'h0800, 13'h1000, 4'd0, 8, 1'b0);
      run_vector(13'h0800, 13'h0800, 4'd7, 100, 1'b1);

      // Center with vec_start in the same cycle: the vector starts from center.
      dvx = 13'h0800; dvy = 13'h1800; intensity = 4'd2;
      x_model = 512; y_model = 512;
      center = 1'b1;
      run_vector(13'h0800, 13'h1800, 4'd2, 20, 1'b0);

      // Reset in the middle of a vector aborts without vec_done.
      pulses0 = done_pulses;
      dvx = 13'h0064; dvy = 13'h1064; intensity = 4'd9; vec_start = 1'b1;
      @(negedge clk_12MHz);
      vec_start = 1'b0;
      repeat (49) @(negedge clk_12MHz);
      chk("pre_reset_go", 32'(GO), 32'd1);
      reset = 1'b1;
      @(negedge clk_12MHz);
      reset = 1'b0;
      chk("abort_go", 32'(GO), 32'd0);
      chk("abort_busy", 32'(busy), 32'd0);
      chk("abort_x", 32'(x_pos), 32'd512);
      chk("abort_y", 32'(y_pos), 32'd512);
      chk("abort_done", 32'(vec_done), 32'd0);
      @(negedge clk_12MHz);
      chk("abort_done_later", 32'(vec_done), 32'd0);
      chk("abort_no_pulse", 32'(done_pulses - pulses0), 32'd0);
      $display("reset mid-vector -> x=%0d y=%0d go=%0d busy=%0d", x_pos, y_pos, GO, busy);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
